// File: rtl/multicycle_control_fsm_if.sv
// Control-unit bus: run/instruction/memory handshake in, datapath controls out.
interface multicycle_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             mem_ready;
  logic             mem_req;
  logic             MemRead;
  logic             MemWrite;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             RegRead;
  logic             RegWrite;
  logic [1:0]       reg_dst;
  logic             ALUSrc;
  logic             Branch;
  logic             MemToReg;
  logic [2:0]       state;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;
  logic             fault;

  // Control unit side
  modport master (
    input  run, opcode, funct, mem_ready,
    output mem_req, MemRead, MemWrite, ir_write, pc_write, pc_src,
           RegRead, RegWrite, reg_dst, ALUSrc, Branch, MemToReg,
           state, instr_done, instr_count, fault
  );

  // Datapath / memory / sequencer side
  modport slave (
    output run, opcode, funct, mem_ready,
    input  mem_req, MemRead, MemWrite, ir_write, pc_write, pc_src,
           RegRead, RegWrite, reg_dst, ALUSrc, Branch, MemToReg,
           state, instr_done, instr_count, fault
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control unit: IDLE/FETCH/DECODE/EXEC/MEM/WB sequencing,
// variable-latency memory handshake with timeout fault, retired counter.
module multicycle_control_fsm #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_JR, C_LUI, C_J, C_JAL, C_BR, C_ST, C_LD, C_IALU
  } cls_t;

  // Wait counter only needs to reach MEM_TIMEOUT-1; the last wait cycle is
  // detected by comparison rather than by counting to MEM_TIMEOUT.
  localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST =
    WCNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t           state_q, state_d;
  logic [5:0]       op_q, fn_q;
  logic [WCNT_W-1:0] wait_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             retire, latch, waiting, timeout;
  cls_t             cls;

  // Instruction class from the latched opcode/funct
  always_comb begin
    cls = C_IALU;
    case (op_q)
      6'h00:                      cls = (fn_q == 6'h08) ? C_JR : C_R;
      6'h0F:                      cls = C_LUI;
      6'h02:                      cls = C_J;
      6'h03:                      cls = C_JAL;
      6'h04, 6'h05:               cls = C_BR;
      6'h28, 6'h29, 6'h2B:        cls = C_ST;
      6'h20, 6'h21, 6'h23,
      6'h24, 6'h25:               cls = C_LD;
      default:                    cls = C_IALU;
    endcase
  end

  // Memory wait tracking: a wait cycle is any FETCH/MEM cycle without ready
  always_comb begin
    waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !bus.mem_ready;
    timeout = (MEM_TIMEOUT > 0) && waiting && (wait_q == WAIT_LAST);
  end

  // Next-state and per-state control decode
  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    latch        = 1'b0;
    bus.mem_req  = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.ir_write = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_src   = 2'd0;
    bus.RegRead  = 1'b0;
    bus.RegWrite = 1'b0;
    bus.reg_dst  = 2'd0;
    bus.ALUSrc   = 1'b0;
    bus.Branch   = 1'b0;
    bus.MemToReg = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        bus.mem_req  = 1'b1;
        bus.MemRead  = 1'b1;
        bus.ir_write = bus.mem_ready;
        bus.pc_write = bus.mem_ready;
        if (bus.mem_ready) begin
          latch   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        bus.RegRead = (cls inside {C_R, C_JR, C_BR, C_ST, C_LD});
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        bus.ALUSrc = (cls inside {C_LUI, C_IALU, C_LD, C_ST});
        bus.Branch = (cls == C_BR);
        if (cls inside {C_J, C_JAL}) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = 2'd1;
        end else if (cls == C_JR) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = 2'd2;
        end
        if (cls inside {C_BR, C_J, C_JR}) retire  = 1'b1;
        else if (cls inside {C_LD, C_ST}) state_d = S_MEM;
        else                              state_d = S_WB;
      end
      S_MEM: begin
        bus.mem_req  = 1'b1;
        bus.ALUSrc   = 1'b1;
        bus.MemRead  = (cls == C_LD);
        bus.MemWrite = (cls == C_ST);
        if (bus.mem_ready) begin
          if (cls == C_ST) retire  = 1'b1;
          else             state_d = S_WB;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        bus.RegWrite = 1'b1;
        bus.reg_dst  = (cls == C_R) ? 2'd1 : (cls == C_JAL) ? 2'd2 : 2'd0;
        bus.MemToReg = (cls == C_LD);
        retire       = 1'b1;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    if (retire) state_d = bus.run ? S_FETCH : S_IDLE;
  end

  // State, instruction latch, wait counter and retire bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      fn_q    <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        op_q <= bus.opcode;
        fn_q <= bus.funct;
      end
      // Leaving FETCH/MEM or seeing ready always clears, so entry starts at 0
      wait_q <= waiting ? wait_q + WCNT_W'(1) : '0;
      done_q <= retire;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.state       = state_q;
  assign bus.instr_done  = done_q;
  assign bus.instr_count = cnt_q;
  assign bus.fault       = (state_q == S_FAULT);

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle MIPS control unit: sequences each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB states.
- Drives datapath control signals per state and per instruction class.
- Handshakes with a variable-latency memory, with a timeout fault.
- Keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps).
MEM_TIMEOUT, 16, max consecutive wait cycles in FETCH/MEM before FAULT; 0 disables timeout.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
run  in  1  1: execute; sampled in IDLE and at retire
opcode  in  6  instr[31:26] from memory, valid in FETCH when mem_ready=1
funct  in  6  instr[5:0], same timing as opcode
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request active (FETCH, MEM)
MemRead  out  1  memory read
MemWrite  out  1  memory write
ir_write  out  1  latch instruction register
pc_write  out  1  update PC
pc_src  out  2  0: PC+4, 1: jump target, 2: rs (JR)
RegRead  out  1  register file read
RegWrite  out  1  register file write
reg_dst  out  2  0: rt, 1: rd, 2: $31
ALUSrc  out  1  0: register, 1: immediate
Branch  out  1  branch compare (beq/bne)
MemToReg  out  1  write-back from memory
state  out  3  IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 FAULT=7
instr_done  out  1  one-cycle pulse after retire
instr_count  out  CNT_W  retired instructions
fault  out  1  memory timeout, sticky until reset

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, op/funct latches=0, wait counter=0, instr_count=0, instr_done=0, fault=0. All control outputs 0 in IDLE.
- Outputs are decoded from state and latched op/funct only. Exceptions: ir_write and pc_write in FETCH, which equal mem_ready.
- Classes by latched opcode:
  - R: 0x00; JR is R with funct 0x08.
  - LUI: 0x0F. J: 0x02. JAL: 0x03. BR: 0x04/0x05.
  - ST: 0x28/0x29/0x2B. LD: 0x20/0x21/0x23/0x24/0x25.
  - IALU: every other opcode.
- IDLE: go to FETCH when run=1.
- FETCH: mem_req=1, MemRead=1; ir_write=pc_write=mem_ready with pc_src=0. On mem_ready: latch opcode/funct and go to DECODE; otherwise stay.
- DECODE: RegRead=1 for R, BR, ST, LD. Always go to EXEC next.
- EXEC:
  - ALUSrc=1 for LUI, IALU, LD, ST.
  - Branch=1 for BR.
  - J/JAL: pc_write=1, pc_src=1. JR: pc_write=1, pc_src=2.
  - Next state: BR/J/JR retire; LD/ST go to MEM; all others go to WB.
- MEM: mem_req=1, ALUSrc=1; MemRead=1 for LD, MemWrite=1 for ST. On mem_ready: ST retires, LD goes to WB. Stay while mem_ready=0.
- WB: RegWrite=1; reg_dst=1 for R, 2 for JAL, else 0; MemToReg=1 for LD. Then retire.
- Retire: next state is FETCH if run=1, else IDLE. At the same edge set instr_done=1 for exactly one cycle and increment instr_count modulo 2^CNT_W.
- Timeout:
  - Wait counter clears on entry to FETCH/MEM and increments on each cycle there with mem_ready=0.
  - If MEM_TIMEOUT>0 and the MEM_TIMEOUT-th consecutive wait cycle ends with mem_ready=0, go to FAULT.
  - mem_ready arriving in that same cycle wins: no fault.
- FAULT: all controls 0, fault=1, state held until reset; run is ignored.
- Reset mid-instruction (any state): same result as power-on reset; the partial instruction is discarded and not counted.
- Latency with zero-wait memory: R/IALU/LUI/JAL = 4 cycles; BR/J/JR = 3; ST = 4; LD = 5. Each memory wait cycle adds 1.

Test Plan:
- Reset, run=1, opcode=0x00 funct=0x20, mem_ready=1 -> states 1,2,3,5,1. RegRead=1 in DECODE; RegWrite=1 with reg_dst=1 in WB only. instr_done pulses once; instr_count=1.
- lw (0x23), mem_ready low for 2 cycles in MEM -> MEM lasts 3 cycles with MemRead=1, then WB with MemToReg=1, RegWrite=1; total 7 cycles.
- sw (0x2B) then beq (0x04) -> sw: MemWrite=1 in MEM, RegWrite never 1. beq: Branch=1 in EXEC and retires after 3 cycles. instr_count=2.
- jal (0x03) then jr (0x00/0x08) -> jal: pc_src=1 in EXEC, reg_dst=2 in WB. jr: pc_src=2, pc_write=1 in EXEC, no RegWrite.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH -> state=7 after 4 wait cycles and stays; fault=1. Repeat with mem_ready=1 on the 4th wait cycle -> DECODE, no fault.
- rst_n=0 during MEM of lw -> next cycle state=0, outputs 0, instr_count unchanged at 0. Also: run=0 at retire -> IDLE.
